// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS debug display block.
package mips_dbg_pkg;

  // Readout sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_LATCH = 2'd2
  } dbg_state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int NUM_DIGITS = 8;

endpackage

// File: rtl/hex_to_7seg.sv
// Nibble to active-low seven-segment decoder, purely combinational.
module hex_to_7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Standard hex glyphs, segment order {g,f,e,d,c,b,a}, lit segment = 0
  always_comb begin
    o_seg = 7'b1111111;
    case (i_nibble)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/mips_debug_display.sv
// Periodic debug readout: samples the PC or a register-file entry on each
// refresh tick and shows the 32-bit result on eight seven-segment digits.
module mips_debug_display
  import mips_dbg_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1024,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel,
  input  logic        show_pc,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  output logic        dbg_req,
  output logic [4:0]  dbg_addr,
  input  logic        dbg_ack,
  input  logic [31:0] dbg_data,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  dbg_state_e r_state;
  dbg_state_e w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to;
  logic             r_req;
  logic [4:0]       r_addr;
  logic             r_busy;
  logic             r_err;
  logic [31:0]      r_value;

  logic [NUM_DIGITS-1:0][6:0] r_hex;
  logic [NUM_DIGITS-1:0][6:0] w_seg;

  logic w_tick;
  logic w_cap_sel;
  logic w_cap_pc;
  logic w_cap_ack;
  logic w_timeout;

  assign w_tick = (r_cnt == CNT_LAST);

  // Free-running refresh counter; its wrap cycle is the sample tick
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and capture strobes; ticks outside IDLE fall through unused
  always_comb begin
    w_state_nxt = r_state;
    w_cap_sel   = 1'b0;
    w_cap_pc    = 1'b0;
    w_cap_ack   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && !freeze) begin
          if (show_pc) begin
            w_cap_pc    = 1'b1;
            w_state_nxt = ST_LATCH;
          end else begin
            w_cap_sel   = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still wins over the timeout
        if (dbg_ack) begin
          w_cap_ack   = 1'b1;
          w_state_nxt = ST_LATCH;
        end else if (r_to == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake control: request, address, busy, error and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
      r_to   <= '0;
    end else begin
      if (r_state == ST_REQ) r_to <= r_to + 1'b1;
      if (w_cap_sel) begin
        r_req  <= 1'b1;
        r_addr <= sel;
        r_busy <= 1'b1;
        r_to   <= '0;
      end
      if (w_cap_ack) begin
        r_req  <= 1'b0;
        r_busy <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_timeout) begin
        r_req  <= 1'b0;
        r_busy <= 1'b0;
        r_err  <= 1'b1;
      end
    end
  end

  // Sampled value: PC on a PC tick, read data on ack; a timeout keeps it
  always_ff @(posedge clk) begin
    if (rst)            r_value <= '0;
    else if (w_cap_pc)  r_value <= pc_in;
    else if (w_cap_ack) r_value <= dbg_data;
  end

  genvar g;
  for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_to_7seg u_seg (
      .i_nibble (r_value[4*g +: 4]),
      .o_seg    (w_seg[g])
    );
  end

  // Display registers load only in LATCH; dashes flag a timed-out sample
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_hex[i] <= SEG_BLANK;
    end else if (r_state == ST_LATCH) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_hex[i] <= r_err ? SEG_DASH : w_seg[i];
    end
  end

  assign dbg_req  = r_req;
  assign dbg_addr = r_addr;
  assign busy     = r_busy;
  assign err      = r_err;
  assign hex0     = r_hex[0];
  assign hex1     = r_hex[1];
  assign hex2     = r_hex[2];
  assign hex3     = r_hex[3];
  assign hex4     = r_hex[4];
  assign hex5     = r_hex[5];
  assign hex6     = r_hex[6];
  assign hex7     = r_hex[7];

endmodule

// File: tb/tb_mips_debug_display.sv
// Bench for mips_debug_display: table of sample transactions plus hand-built
// freeze and mid-transaction reset sequences, scored through an expected queue.
module tb_mips_debug_display;

  localparam int R  = 40;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, show_pc, freeze, dbg_ack;
  logic [4:0]  sel, dbg_addr;
  logic [31:0] pc_in, dbg_data;
  logic        dbg_req, busy, err;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  always #5 clk = ~clk;

  mips_debug_display #(.REFRESH_CYCLES(R), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .show_pc(show_pc), .freeze(freeze),
    .pc_in(pc_in), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
    .dbg_data(dbg_data), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7), .busy(busy), .err(err)
  );

  typedef struct {
    bit          show_pc;
    logic [4:0]  sel;
    logic [31:0] value;
    int          ack_dly;  // -1: responder never acks
    bit          exp_err;
  } vec_t;

  localparam logic [55:0] BLANK_ALL = {8{7'b1111111}};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_cnt;
  logic [55:0] exp_q[$];
  logic [55:0] m_disp;
  bit          m_err;
  vec_t        tbl[7];

  // Reference model of the refresh counter, used to locate ticks
  always @(posedge clk) begin
    if (rst) m_cnt <= 0;
    else     m_cnt <= (m_cnt == R - 1) ? 0 : m_cnt + 1;
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [55:0] exp_disp(input logic [31:0] v, input bit dash);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = dash ? 7'b0111111 : ref_seg(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [55:0] disp();
    return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    logic [55:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, disp(), e);
      m_disp = e;
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * R + 4; i++) begin
      if (m_cnt == R - 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_wait: got none expected tick within %0d cycles", 2 * R + 4);
    end
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    bit ok;
    int n;
    show_pc = v.show_pc;
    sel     = v.sel;
    freeze  = 1'b0;
    pc_in   = v.show_pc ? v.value : 32'hDEAD_0000;
    wait_tick(ok);
    if (!ok) return;
    if (v.show_pc) begin
      exp_q.push_back(exp_disp(v.value, m_err));
      @(negedge clk);
      pc_in = 32'hFFFF_FFFF;
      check($sformatf("v%0d_pc_noreq", idx), dbg_req, 0);
      check($sformatf("v%0d_pc_hold", idx), disp(), m_disp);
      @(negedge clk);
      pop_check($sformatf("v%0d_pc_disp", idx));
      check($sformatf("v%0d_err", idx), err, v.exp_err);
    end else begin
      @(negedge clk);
      check($sformatf("v%0d_req", idx), dbg_req, 1);
      check($sformatf("v%0d_addr", idx), dbg_addr, v.sel);
      check($sformatf("v%0d_busy", idx), busy, 1);
      if (v.ack_dly < 0) begin
        n = 0;
        while (dbg_req === 1'b1 && n < 100) begin
          n++;
          @(negedge clk);
        end
        check($sformatf("v%0d_req_cycles", idx), n, TO);
        exp_q.push_back(exp_disp(32'h0, 1'b1));
        check($sformatf("v%0d_hold", idx), disp(), m_disp);
        @(negedge clk);
        pop_check($sformatf("v%0d_dash", idx));
      end else begin
        for (int k = 0; k < v.ack_dly; k++) @(negedge clk);
        check($sformatf("v%0d_req_held", idx), dbg_req, 1);
        dbg_ack  = 1'b1;
        dbg_data = v.value;
        exp_q.push_back(exp_disp(v.value, 1'b0));
        @(negedge clk);
        dbg_ack  = 1'b0;
        dbg_data = $urandom;
        check($sformatf("v%0d_req_drop", idx), dbg_req, 0);
        check($sformatf("v%0d_busy_drop", idx), busy, 0);
        check($sformatf("v%0d_hold", idx), disp(), m_disp);
        @(negedge clk);
        pop_check($sformatf("v%0d_disp", idx));
      end
      check($sformatf("v%0d_err", idx), err, v.exp_err);
    end
    m_err = v.exp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int hi;
    tbl[0] = '{1'b0, 5'd9,  32'h1234_ABCD, 0,  1'b0};
    tbl[1] = '{1'b1, 5'd0,  32'h0000_0040, 0,  1'b0};
    tbl[2] = '{1'b0, 5'd31, 32'hDEAD_BEEF, 3,  1'b0};
    tbl[3] = '{1'b0, 5'd5,  32'h0,         -1, 1'b1};
    tbl[4] = '{1'b0, 5'd0,  32'h0000_0000, 0,  1'b0};
    tbl[5] = '{1'b1, 5'd0,  32'h89AB_CDEF, 0,  1'b0};
    tbl[6] = '{1'b0, 5'd17, 32'hF0F0_5678, TO - 1, 1'b0};

    rst = 1'b1; show_pc = 1'b0; freeze = 1'b0; sel = '0;
    pc_in = '0; dbg_ack = 1'b0; dbg_data = '0;
    m_err = 1'b0; m_disp = BLANK_ALL;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, held until just before the first tick
    check("rst_disp", disp(), BLANK_ALL);
    check("rst_req", dbg_req, 0);
    check("rst_addr", dbg_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    hi = 0;
    while (m_cnt < R - 2) begin
      @(negedge clk);
      if (dbg_req || busy) hi++;
    end
    check("pre_tick_idle", hi, 0);
    check("pre_tick_disp", disp(), BLANK_ALL);

    for (int i = 0; i < 7; i++) begin
      do_vec(tbl[i], i);
      if (i == 0) begin
        check("v0_hex0_D", hex0, 7'b0100001);
        check("v0_hex7_1", hex7, 7'b1111001);
      end
      if (i == 1) begin
        check("v1_hex1_4", hex1, 7'b0011001);
        check("v1_hex7_0", hex7, 7'b1000000);
      end
    end

    // Freeze and sel change while a read is in flight
    show_pc = 1'b0; freeze = 1'b0; sel = 5'd3;
    wait_tick(ok);
    if (ok) begin
      @(negedge clk);
      check("frz_addr0", dbg_addr, 3);
      freeze = 1'b1;
      sel    = 5'd20;
      @(negedge clk);
      check("frz_addr1", dbg_addr, 3);
      check("frz_req", dbg_req, 1);
      dbg_ack  = 1'b1;
      dbg_data = 32'h0000_0777;
      exp_q.push_back(exp_disp(32'h0000_0777, 1'b0));
      @(negedge clk);
      dbg_ack = 1'b0;
      check("frz_req_drop", dbg_req, 0);
      @(negedge clk);
      pop_check("frz_disp");
      hi = 0;
      for (int i = 0; i < 3 * R + 5; i++) begin
        @(negedge clk);
        if (dbg_req) hi++;
      end
      check("frz_no_req", hi, 0);
      check("frz_hold", disp(), m_disp);
    end
    freeze = 1'b0;

    // Reset in the middle of a request, then a stray late ack
    sel = 5'd7;
    wait_tick(ok);
    if (ok) begin
      @(negedge clk);
      check("mid_req", dbg_req, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_req", dbg_req, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_disp", disp(), BLANK_ALL);
      rst      = 1'b0;
      dbg_ack  = 1'b1;
      dbg_data = 32'hFFFF_FFFF;
      @(negedge clk);
      dbg_ack = 1'b0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (dbg_req || busy) hi++;
      end
      check("late_ack_idle", hi, 0);
      check("late_ack_disp", disp(), BLANK_ALL);
      check("late_ack_err", err, 0);
    end
    m_err  = 1'b0;
    m_disp = BLANK_ALL;
    do_vec(tbl[0], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
